// File: rtl/four_bit_sync_down_cntr_pkg.sv
// Shared constants and types for the 4-bit synchronous down counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package four_bit_sync_down_cntr_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [1:0]       mode_t;

  // Terminal-behaviour encodings applied when a decrement is requested at zero.
  localparam mode_t MODE_WRAP    = 2'b00;
  localparam mode_t MODE_RELOAD  = 2'b01;
  localparam mode_t MODE_ONESHOT = 2'b10;
  // The remaining encoding is reserved and falls back to wrap behaviour.
  localparam mode_t MODE_RSVD    = 2'b11;

  localparam cnt_t CNT_ZERO = '0;
  localparam cnt_t CNT_MAX  = '1;

  // Value the counter takes when it is asked to decrement while at zero.
  // One-shot parks at zero; the completion flag is handled by the caller.
  function automatic cnt_t terminal_count(input mode_t mode, input cnt_t reload_val);
    cnt_t nxt;
    case (mode)
      MODE_RELOAD:  nxt = reload_val;
      MODE_ONESHOT: nxt = CNT_ZERO;
      default:      nxt = CNT_MAX;
    endcase
    return nxt;
  endfunction

  // True when the terminal event should latch the one-shot completion flag.
  function automatic logic terminal_sets_done(input mode_t mode);
    return (mode == MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/four_bit_sync_down_cntr.sv
// 4-bit loadable synchronous down counter with wrap / auto-reload / one-shot terminal modes.
// Latency: count and done update one clk after load/cnt_en; borrow is combinational (zero cycles).
// Backpressure: none; cnt_en gates progress, and a finished one-shot ignores cnt_en until reloaded.
module four_bit_sync_down_cntr
  import four_bit_sync_down_cntr_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       cnt_en,
  input  logic       load,
  input  logic [3:0] I,
  input  logic [1:0] mode,
  output logic [3:0] count,
  output logic       borrow,
  output logic       done
);

  // Value restored on a reload-mode terminal event; captured on every load.
  cnt_t reload_reg;

  logic at_zero;
  logic dec_req;

  assign at_zero = (count == CNT_ZERO);

  // A decrement is requested when enabled, not overridden by load, and the
  // one-shot has not already completed.
  assign dec_req = cnt_en & ~load & ~done;

  // Cascade borrow: the next stage up decrements in the same cycle this stage
  // leaves zero. Reset forces count/done low, so borrow tracks cnt_en & ~load there.
  assign borrow = dec_req & at_zero;

  // Counter state: load has priority, then enabled decrement, otherwise hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count      <= CNT_ZERO;
      reload_reg <= CNT_ZERO;
      done       <= 1'b0;
    end else if (load) begin
      count      <= I;
      reload_reg <= I;
      done       <= 1'b0;
    end else if (cnt_en && !done) begin
      if (!at_zero) begin
        count <= count - cnt_t'(1);
      end else begin
        count <= terminal_count(mode, reload_reg);
        if (terminal_sets_done(mode)) begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_four_bit_sync_down_cntr.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
// Latency: checks borrow before each posedge and count/done on the following negedge.
// Backpressure: n/a.
module tb_four_bit_sync_down_cntr;

  logic       clk;
  logic       rstn;
  logic       cnt_en;
  logic       load;
  logic [3:0] din;
  logic [1:0] mode;
  logic [3:0] count;
  logic       borrow;
  logic       done;

  // Cascade pair: low stage borrow drives high stage enable.
  logic       c_en;
  logic       c_ld;
  logic [7:0] c_val_in;
  logic [3:0] lo_cnt;
  logic [3:0] hi_cnt;
  logic       lo_borrow;
  logic       hi_borrow;
  logic       lo_done;
  logic       hi_done;

  int tests = 0;
  int fails = 0;

  // Behavioural reference state.
  int m_cnt;
  int m_rel;
  int m_done;
  int c_model;

  logic b_obs;
  logic b_exp;

  four_bit_sync_down_cntr dut (
    .clk    (clk),
    .rstn   (rstn),
    .cnt_en (cnt_en),
    .load   (load),
    .I      (din),
    .mode   (mode),
    .count  (count),
    .borrow (borrow),
    .done   (done)
  );

  four_bit_sync_down_cntr u_lo (
    .clk    (clk),
    .rstn   (rstn),
    .cnt_en (c_en),
    .load   (c_ld),
    .I      (c_val_in[3:0]),
    .mode   (2'b00),
    .count  (lo_cnt),
    .borrow (lo_borrow),
    .done   (lo_done)
  );

  four_bit_sync_down_cntr u_hi (
    .clk    (clk),
    .rstn   (rstn),
    .cnt_en (lo_borrow),
    .load   (c_ld),
    .I      (c_val_in[7:4]),
    .mode   (2'b00),
    .count  (hi_cnt),
    .borrow (hi_borrow),
    .done   (hi_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: borrow is "asked to go below zero this cycle".
  function automatic logic model_borrow();
    return cnt_en && !load && (m_done == 0) && (m_cnt == 0);
  endfunction

  // Model: one clock of counter behaviour described arithmetically.
  task automatic model_clk();
    if (load) begin
      m_cnt  = int'(din);
      m_rel  = int'(din);
      m_done = 0;
    end else if (cnt_en && m_done == 0) begin
      if (m_cnt > 0)              m_cnt = m_cnt - 1;
      else if (mode == 2'b01)     m_cnt = m_rel;
      else if (mode == 2'b10)     m_done = 1;
      else                        m_cnt = (m_cnt + 15) % 16;
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_rel  = 0;
    m_done = 0;
    c_model = 0;
  endtask

  // One cycle: called just after a negedge; returns at the next negedge.
  task automatic step(input logic en, input logic ld, input logic [3:0] i, input logic [1:0] m);
    cnt_en = en;
    load   = ld;
    din    = i;
    mode   = m;
    #1;
    b_obs = borrow;
    b_exp = model_borrow();
    @(posedge clk);
    model_clk();
    @(negedge clk);
  endtask

  task automatic step_chk(input string tag, input logic en, input logic ld,
                          input logic [3:0] i, input logic [1:0] m);
    step(en, ld, i, m);
    chk({tag, ".borrow"}, 8'(b_obs), 8'(b_exp));
    chk({tag, ".count"},  8'(count), 8'(m_cnt));
    chk({tag, ".done"},   8'(done),  8'(m_done));
  endtask

  // Cascade cycle: drives the pair, updates the 8-bit model.
  task automatic cstep(input logic en, input logic ld, input logic [7:0] v);
    c_en     = en;
    c_ld     = ld;
    c_val_in = v;
    @(posedge clk);
    if (ld)      c_model = int'(v);
    else if (en) c_model = (c_model + 255) % 256;
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid low-phase; checks it acts before any posedge.
  task automatic async_reset(input string tag);
    #2;
    rstn = 1'b0;
    #1;
    chk({tag, ".async_cnt"},  8'(count), 8'h00);
    chk({tag, ".async_done"}, 8'(done),  8'h00);
    chk({tag, ".async_brw"},  8'(borrow), 8'(cnt_en & ~load));
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".held_cnt"}, 8'(count), 8'h00);
    rstn = 1'b1;
    model_reset();
  endtask

  int exp28_c [5] = '{2, 1, 0, 15, 14};
  int exp28_b [5] = '{0, 0, 0, 1, 0};
  int exp29_c [9] = '{1, 0, 2, 1, 0, 2, 1, 0, 2};
  int exp29_b [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
  int exp30_d [4] = '{0, 1, 1, 1};
  int exp30_b [4] = '{0, 1, 0, 0};

  initial begin
    rstn     = 1'b0;
    cnt_en   = 1'b0;
    load     = 1'b0;
    din      = 4'h0;
    mode     = 2'b00;
    c_en     = 1'b0;
    c_ld     = 1'b0;
    c_val_in = 8'h00;
    model_reset();

    // Reset state and borrow behaviour while held in reset.
    @(negedge clk);
    @(negedge clk);
    chk("rst.count",  8'(count),  8'h00);
    chk("rst.done",   8'(done),   8'h00);
    chk("rst.borrow", 8'(borrow), 8'h00);
    cnt_en = 1'b1;
    #1;
    chk("rst.borrow_en", 8'(borrow), 8'h01);
    load = 1'b1;
    #1;
    chk("rst.borrow_ld", 8'(borrow), 8'h00);
    cnt_en = 1'b0;
    load   = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Wrap mode: 3,2,1,0,F,E with borrow only while at zero.
    step(1'b0, 1'b1, 4'h3, 2'b00);
    chk("r28.load", 8'(count), 8'h03);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 4'h0, 2'b00);
      chk($sformatf("r28.c%0d", k), 8'(count), 8'(exp28_c[k]));
      chk($sformatf("r28.b%0d", k), 8'(b_obs), 8'(exp28_b[k]));
    end

    // Hold with cnt_en low.
    step(1'b0, 1'b0, 4'h9, 2'b01);
    chk("hold.count", 8'(count), 8'h0E);

    // Auto-reload divide-by-3.
    step(1'b0, 1'b1, 4'h2, 2'b01);
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 1'b0, 4'h0, 2'b01);
      chk($sformatf("r29.c%0d", k), 8'(count), 8'(exp29_c[k]));
      chk($sformatf("r29.b%0d", k), 8'(b_obs), 8'(exp29_b[k]));
    end

    // One-shot: 1,0,0,0; done latched; borrow once; then reload clears done.
    step(1'b0, 1'b1, 4'h1, 2'b10);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 4'h0, 2'b10);
      chk($sformatf("r30.c%0d", k), 8'(count), 8'h00);
      chk($sformatf("r30.d%0d", k), 8'(done),  8'(exp30_d[k]));
      chk($sformatf("r30.b%0d", k), 8'(b_obs), 8'(exp30_b[k]));
    end
    // done persists across a mode change.
    step(1'b1, 1'b0, 4'h0, 2'b00);
    chk("r20.count", 8'(count), 8'h00);
    chk("r20.done",  8'(done),  8'h01);
    chk("r20.borrow", 8'(b_obs), 8'h00);
    step(1'b0, 1'b1, 4'h5, 2'b10);
    chk("r30.reload_cnt",  8'(count), 8'h05);
    chk("r30.reload_done", 8'(done),  8'h00);

    // Load beats enable.
    step(1'b0, 1'b1, 4'h7, 2'b00);
    step(1'b1, 1'b1, 4'hA, 2'b00);
    chk("r31.count",  8'(count), 8'h0A);
    chk("r31.borrow", 8'(b_obs), 8'h00);

    // Reload value of zero keeps count at zero with borrow every enabled cycle.
    step(1'b0, 1'b1, 4'h0, 2'b01);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 4'h0, 2'b01);
      chk($sformatf("r21.c%0d", k), 8'(count), 8'h00);
      chk($sformatf("r21.b%0d", k), 8'(b_obs), 8'h01);
    end

    // Async reset mid-count at 9, then counting resumes from 0.
    step(1'b0, 1'b1, 4'h9, 2'b00);
    chk("r33.pre", 8'(count), 8'h09);
    cnt_en = 1'b1;
    load   = 1'b0;
    async_reset("r33a");
    step(1'b1, 1'b0, 4'h0, 2'b00);
    chk("r33.resume_b", 8'(b_obs), 8'h01);
    chk("r33.resume_c", 8'(count), 8'h0F);

    // Async reset clears a latched done.
    step(1'b0, 1'b1, 4'h0, 2'b10);
    step(1'b1, 1'b0, 4'h0, 2'b10);
    chk("r33.done_set", 8'(done), 8'h01);
    cnt_en = 1'b0;
    async_reset("r33b");
    step(1'b0, 1'b0, 4'h0, 2'b10);
    chk("r33.done_clr", 8'(done), 8'h00);

    // Cascade: load 0x10, two enables -> 0x0F then 0x0E, then a longer run.
    cstep(1'b0, 1'b1, 8'h10);
    chk("r32.load", {hi_cnt, lo_cnt}, 8'h10);
    cstep(1'b1, 1'b0, 8'h00);
    chk("r32.s1", {hi_cnt, lo_cnt}, 8'h0F);
    cstep(1'b1, 1'b0, 8'h00);
    chk("r32.s2", {hi_cnt, lo_cnt}, 8'h0E);
    cstep(1'b0, 1'b1, 8'h02);
    for (int k = 0; k < 40; k++) begin
      cstep(1'($urandom_range(0, 3) != 0), 1'b0, 8'h00);
      chk($sformatf("casc.%0d", k), {hi_cnt, lo_cnt}, 8'(c_model));
    end
    c_en = 1'b0;

    // Randomized traffic against the model, with occasional async resets.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 59) == 0) begin
        cnt_en = 1'($urandom_range(0, 1));
        load   = 1'b0;
        async_reset($sformatf("rnd%0d", k));
      end else begin
        step_chk($sformatf("rnd%0d", k),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 7) == 0),
                 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
